// File: rtl/phase_sequence_monitor.sv
// Phase sequence monitor: checks that a 3-bit mod-8 phase advances by one each clock and locks onto it.
// While locked it drives slot strobes and a frame-start pulse, and keeps saturating lap and error counts.
module phase_sequence_monitor #(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_LIMIT  = 3,
  parameter int WRAP_W     = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [2:0]        i_state_in,
  input  logic              i_clear_stats,
  output logic              o_locked,
  output logic              o_seq_err,
  output logic              o_frame_start,
  output logic [7:0]        o_slot_onehot,
  output logic [WRAP_W-1:0] o_wrap_count,
  output logic [7:0]        o_err_count
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2,
    SLIP   = 2'd3
  } state_t;

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(ERR_LIMIT + 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(ERR_LIMIT - 1);
  localparam logic [WRAP_W-1:0] WRAP_MAX  = {WRAP_W{1'b1}};

  state_t              r_state;
  logic [2:0]          r_prev;
  logic                r_prev_valid;
  logic [RUN_W-1:0]    r_run;
  logic [MISS_W-1:0]   r_miss;

  logic [2:0]          w_next_phase;
  logic                w_match;
  logic                w_in_lock;
  logic                w_lock_hit;
  logic                w_bad;
  logic                w_wrap;

  assign w_next_phase = r_prev + 3'd1;
  assign w_match      = r_prev_valid & (i_state_in == w_next_phase);
  assign w_in_lock    = (r_state == LOCKED) | (r_state == SLIP);
  // Strobes key off the state held during the sample, so the entry cycle into LOCKED stays quiet.
  assign w_lock_hit   = (r_state == LOCKED) & w_match;
  assign w_bad        = w_in_lock & ~w_match;
  assign w_wrap       = w_lock_hit & (r_prev == 3'd7);

  // Lock FSM, phase history, registered strobes and statistics counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= SEARCH;
      r_prev        <= 3'd0;
      r_prev_valid  <= 1'b0;
      r_run         <= '0;
      r_miss        <= '0;
      o_locked      <= 1'b0;
      o_seq_err     <= 1'b0;
      o_frame_start <= 1'b0;
      o_slot_onehot <= 8'd0;
      o_wrap_count  <= '0;
      o_err_count   <= 8'd0;
    end else begin
      r_prev        <= i_state_in;
      r_prev_valid  <= 1'b1;
      o_seq_err     <= w_bad;
      o_frame_start <= w_lock_hit & (i_state_in == 3'd0);
      o_slot_onehot <= w_lock_hit ? (8'd1 << i_state_in) : 8'd0;

      if (i_clear_stats) begin
        o_wrap_count <= '0;
        o_err_count  <= 8'd0;
      end else begin
        if (w_wrap && (o_wrap_count != WRAP_MAX)) o_wrap_count <= o_wrap_count + 1'b1;
        if (w_bad && (o_err_count != 8'hFF))      o_err_count  <= o_err_count + 8'd1;
      end

      case (r_state)
        SEARCH: begin
          if (w_match) begin
            if (LOCK_COUNT == 1) begin
              r_state  <= LOCKED;
              r_run    <= '0;
              o_locked <= 1'b1;
            end else begin
              r_state  <= VERIFY;
              r_run    <= RUN_W'(1);
              o_locked <= 1'b0;
            end
          end else begin
            o_locked <= 1'b0;
          end
        end
        VERIFY: begin
          if (w_match && (r_run == RUN_LAST)) begin
            r_state  <= LOCKED;
            r_run    <= '0;
            o_locked <= 1'b1;
          end else if (w_match) begin
            r_run    <= r_run + 1'b1;
            o_locked <= 1'b0;
          end else begin
            r_state  <= SEARCH;
            r_run    <= '0;
            o_locked <= 1'b0;
          end
        end
        LOCKED: begin
          if (w_match) begin
            o_locked <= 1'b1;
          end else if (ERR_LIMIT == 1) begin
            r_state  <= SEARCH;
            r_run    <= '0;
            r_miss   <= '0;
            o_locked <= 1'b0;
          end else begin
            r_state  <= SLIP;
            r_miss   <= MISS_W'(1);
            o_locked <= 1'b1;
          end
        end
        SLIP: begin
          if (w_match) begin
            r_state  <= LOCKED;
            r_miss   <= '0;
            o_locked <= 1'b1;
          end else if (r_miss == MISS_LAST) begin
            r_state  <= SEARCH;
            r_miss   <= '0;
            r_run    <= '0;
            o_locked <= 1'b0;
          end else begin
            r_miss   <= r_miss + 1'b1;
            o_locked <= 1'b1;
          end
        end
        default: begin
          r_state  <= SEARCH;
          r_run    <= '0;
          r_miss   <= '0;
          o_locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sequence_monitor.sv
// Bench for phase_sequence_monitor: a behavioural model pushes expected outputs per sample into a
// scoreboard queue that a monitor drains one cycle later; scenario tasks add targeted inline checks.
module tb_phase_sequence_monitor;

  logic       clk;
  logic       reset;
  logic [2:0] state_in;
  logic       clear_stats;

  logic       locked, seq_err, frame_start;
  logic [7:0] slot_onehot, wrap_count, err_count;
  logic       locked2, seq_err2, frame_start2;
  logic [7:0] slot_onehot2, err_count2;
  logic [1:0] wrap_count2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       locked;
    logic       seq_err;
    logic       frame;
    logic [7:0] slot;
    logic [7:0] wrap8;
    logic [1:0] wrap2;
    logic [7:0] err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // Model state (LOCK_COUNT=4, ERR_LIMIT=3 hard-coded)
  int         m_fsm;   // 0 SEARCH, 1 VERIFY, 2 LOCKED, 3 SLIP
  logic [2:0] m_prev;
  bit         m_pv;
  int         m_run, m_miss, m_wrap8, m_wrap2, m_err;

  phase_sequence_monitor u_dut (
    .i_clk(clk), .i_reset(reset), .i_state_in(state_in), .i_clear_stats(clear_stats),
    .o_locked(locked), .o_seq_err(seq_err), .o_frame_start(frame_start),
    .o_slot_onehot(slot_onehot), .o_wrap_count(wrap_count), .o_err_count(err_count)
  );

  phase_sequence_monitor #(.WRAP_W(2)) u_dut_w2 (
    .i_clk(clk), .i_reset(reset), .i_state_in(state_in), .i_clear_stats(clear_stats),
    .o_locked(locked2), .o_seq_err(seq_err2), .o_frame_start(frame_start2),
    .o_slot_onehot(slot_onehot2), .o_wrap_count(wrap_count2), .o_err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Drive one sample at the falling edge, predict its registered outputs, wait until they appear.
  task automatic step(input logic [2:0] st, input logic clr, input logic rst);
    exp_t e;
    bit   mt, hit, bad;
    int   nf;
    @(negedge clk);
    state_in    = st;
    clear_stats = clr;
    reset       = rst;
    e = '0;
    if (rst) begin
      m_fsm = 0; m_prev = 3'd0; m_pv = 0; m_run = 0; m_miss = 0;
      m_wrap8 = 0; m_wrap2 = 0; m_err = 0;
    end else begin
      mt  = m_pv && (int'(st) == ((int'(m_prev) + 1) % 8));
      hit = (m_fsm == 2) && mt;
      bad = (m_fsm >= 2) && !mt;
      if (clr) begin
        m_wrap8 = 0; m_wrap2 = 0; m_err = 0;
      end else begin
        if (hit && m_prev == 3'd7) begin
          if (m_wrap8 < 255) m_wrap8++;
          if (m_wrap2 < 3)   m_wrap2++;
        end
        if (bad && m_err < 255) m_err++;
      end
      nf = m_fsm;
      case (m_fsm)
        0: if (mt) begin nf = 1; m_run = 1; end
        1: if (mt) begin m_run++; if (m_run == 4) nf = 2; end
           else begin nf = 0; m_run = 0; end
        2: if (!mt) begin nf = 3; m_miss = 1; end
        default: if (mt) begin nf = 2; m_miss = 0; end
                 else begin
                   m_miss++;
                   if (m_miss == 3) begin nf = 0; m_miss = 0; m_run = 0; end
                 end
      endcase
      e.locked  = (nf >= 2);
      e.seq_err = bad;
      e.frame   = hit && (st == 3'd0);
      e.slot    = hit ? (8'd1 << st) : 8'd0;
      e.wrap8   = 8'(m_wrap8);
      e.wrap2   = 2'(m_wrap2);
      e.err     = 8'(m_err);
      m_prev = st; m_pv = 1; m_fsm = nf;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: compare both DUTs against the oldest pending expectation.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checks++; if (locked !== mon_e.locked) begin errors++; $display("FAIL sb_locked got %0b exp %0b t=%0t", locked, mon_e.locked, $time); end
      checks++; if (seq_err !== mon_e.seq_err) begin errors++; $display("FAIL sb_seq_err got %0b exp %0b t=%0t", seq_err, mon_e.seq_err, $time); end
      checks++; if (frame_start !== mon_e.frame) begin errors++; $display("FAIL sb_frame got %0b exp %0b t=%0t", frame_start, mon_e.frame, $time); end
      checks++; if (slot_onehot !== mon_e.slot) begin errors++; $display("FAIL sb_slot got %h exp %h t=%0t", slot_onehot, mon_e.slot, $time); end
      checks++; if (wrap_count !== mon_e.wrap8) begin errors++; $display("FAIL sb_wrap got %0d exp %0d t=%0t", wrap_count, mon_e.wrap8, $time); end
      checks++; if (err_count !== mon_e.err) begin errors++; $display("FAIL sb_err got %0d exp %0d t=%0t", err_count, mon_e.err, $time); end
      checks++; if (wrap_count2 !== mon_e.wrap2) begin errors++; $display("FAIL sb_wrap_w2 got %0d exp %0d t=%0t", wrap_count2, mon_e.wrap2, $time); end
      checks++; if ({locked2, seq_err2, frame_start2, slot_onehot2, err_count2} !==
                    {mon_e.locked, mon_e.seq_err, mon_e.frame, mon_e.slot, mon_e.err}) begin
        errors++; $display("FAIL sb_w2_outputs got %h exp %h t=%0t",
          {locked2, seq_err2, frame_start2, slot_onehot2, err_count2},
          {mon_e.locked, mon_e.seq_err, mon_e.frame, mon_e.slot, mon_e.err}, $time);
      end
    end
  end

  task automatic test_reset();
    step(3'd0, 1'b0, 1'b1);
    step(3'd0, 1'b0, 1'b1);
    checks++;
    if ({locked, seq_err, frame_start, slot_onehot, wrap_count, err_count} !== 27'd0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {locked, seq_err, frame_start, slot_onehot, wrap_count, err_count});
    end
  endtask

  task automatic test_lock_acquire();
    for (int i = 0; i < 8; i++) begin
      step(3'(i), 1'b0, 1'b0);
      if (i == 3) begin
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL acq_not_yet got %0b exp 0", locked); end
      end
      if (i == 4) begin
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL acq_locked got %0b exp 1", locked); end
      end
    end
    step(3'd0, 1'b0, 1'b0);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL acq_frame got %0b exp 1", frame_start); end
    checks++; if (wrap_count !== 8'd1) begin errors++; $display("FAIL acq_wrap got %0d exp 1", wrap_count); end
    step(3'd1, 1'b0, 1'b0);
  endtask

  task automatic test_skip();
    step(3'd2, 1'b0, 1'b0);
    step(3'd3, 1'b0, 1'b0);
    step(3'd5, 1'b0, 1'b0);
    checks++; if ({seq_err, locked, slot_onehot, err_count} !== {1'b1, 1'b1, 8'h00, 8'd1}) begin
      errors++; $display("FAIL skip_bad got %h exp %h", {seq_err, locked, slot_onehot, err_count}, {1'b1, 1'b1, 8'h00, 8'd1});
    end
    step(3'd6, 1'b0, 1'b0);
    checks++; if ({seq_err, locked, slot_onehot} !== {1'b0, 1'b1, 8'h00}) begin
      errors++; $display("FAIL skip_resync got %h exp %h", {seq_err, locked, slot_onehot}, {1'b0, 1'b1, 8'h00});
    end
    step(3'd7, 1'b0, 1'b0);
    checks++; if (slot_onehot !== 8'h80) begin errors++; $display("FAIL skip_relocked got %h exp 80", slot_onehot); end
  endtask

  task automatic test_hold();
    step(3'd0, 1'b1, 1'b0);
    step(3'd1, 1'b0, 1'b0);
    step(3'd2, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      step(3'd2, 1'b0, 1'b0);
      checks++;
      if ({seq_err, err_count, locked} !== {1'b1, 8'(k), (k < 3)}) begin
        errors++; $display("FAIL hold_%0d got %h exp %h", k, {seq_err, err_count, locked}, {1'b1, 8'(k), (k < 3)});
      end
    end
    for (int p = 3; p <= 6; p++) begin
      step(3'(p), 1'b0, 1'b0);
      checks++;
      if (locked !== (p == 6)) begin errors++; $display("FAIL relock_%0d got %0b exp %0b", p, locked, (p == 6)); end
    end
  endtask

  task automatic test_wrap_saturate();
    for (int lap = 0; lap < 6; lap++) begin
      for (int k = 0; k < 8; k++) step(3'((k + 7) % 8), 1'b0, 1'b0);
    end
    checks++; if (wrap_count2 !== 2'd3) begin errors++; $display("FAIL wrap_w2_sat got %0d exp 3", wrap_count2); end
    checks++; if (wrap_count !== 8'd6) begin errors++; $display("FAIL wrap_w8 got %0d exp 6", wrap_count); end
  endtask

  task automatic test_clear_on_wrap();
    step(3'd7, 1'b0, 1'b0);
    step(3'd0, 1'b1, 1'b0);
    checks++;
    if ({wrap_count, wrap_count2, err_count, frame_start} !== {8'd0, 2'd0, 8'd0, 1'b1}) begin
      errors++; $display("FAIL clear_wrap got %h exp %h", {wrap_count, wrap_count2, err_count, frame_start}, {8'd0, 2'd0, 8'd0, 1'b1});
    end
    clear_stats = 1'b0;
  endtask

  task automatic test_reset_mid();
    step(3'd1, 1'b0, 1'b0);
    step(3'd2, 1'b0, 1'b1);
    checks++;
    if ({locked, seq_err, frame_start, slot_onehot, wrap_count, err_count} !== 27'd0) begin
      errors++; $display("FAIL midreset got %h exp 0", {locked, seq_err, frame_start, slot_onehot, wrap_count, err_count});
    end
    for (int k = 0; k < 5; k++) begin
      step(3'((k + 5) % 8), 1'b0, 1'b0);
      checks++;
      if (locked !== (k == 4)) begin errors++; $display("FAIL midreset_relock_%0d got %0b exp %0b", k, locked, (k == 4)); end
    end
  endtask

  initial begin
    reset = 1'b1;
    state_in = 3'd0;
    clear_stats = 1'b0;
    m_fsm = 0; m_prev = 3'd0; m_pv = 0; m_run = 0; m_miss = 0;
    m_wrap8 = 0; m_wrap2 = 0; m_err = 0;
    test_reset();
    test_lock_acquire();
    test_skip();
    test_hold();
    test_wrap_saturate();
    test_clear_on_wrap();
    test_reset_mid();
    @(posedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL sb_drain got %0d exp 0", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
